// File: rtl/memory_pkg.sv
// Shared types for the memory bank: FSM states, request opcodes and the
// even-parity helper used when MEMORY_BANK_PARITY_EN is defined.
package memory_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Widest data word the parity helper covers; narrower words are zero-extended.
  localparam int PARITY_MAX_W = 64;

  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/memory_bank_if.sv
// Request/response bus of the memory bank. Parity signals exist only when
// MEMORY_BANK_PARITY_EN is defined.
interface memory_bank_if
  import memory_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
);

  logic              req_valid;
  logic              req_ready;
  op_t               req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic              clr_start;
  logic              busy;
  logic              rsp_valid;
  logic [WIDTH-1:0]  rsp_rdata;
`ifdef MEMORY_BANK_PARITY_EN
  logic              err_inject;
  logic              parity_err;
`endif

  modport master (
    output req_valid, req_op, req_addr, req_wdata, clr_start,
`ifdef MEMORY_BANK_PARITY_EN
    output err_inject,
    input  parity_err,
`endif
    input  req_ready, busy, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, clr_start,
`ifdef MEMORY_BANK_PARITY_EN
    input  err_inject,
    output parity_err,
`endif
    output req_ready, busy, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/memory_bank_address_decoder.sv
// Address decoder: binary word address plus enable to a one-hot word select,
// with an in-range flag for depths that are not a power of two.
module address_decoder #(
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_en,
  output logic [DEPTH-1:0]  o_sel,
  output logic              o_in_range
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    o_sel      = '0;
    o_in_range = (32'(i_addr) < 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      if (i_en && (i_addr == ADDR_W'(i))) o_sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/memory_bank.sv
// Word-addressable storage bank with valid/ready requests, registered reads and
// a sequenced whole-bank clear. Optional parity: MEMORY_BANK_PARITY_EN.
module memory_bank
  import memory_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  memory_bank_if.slave bus
);

`ifdef MEMORY_BANK_PARITY_EN
  localparam int MEM_W = WIDTH + 1;
`else
  localparam int MEM_W = WIDTH;
`endif

  logic [MEM_W-1:0]  r_mem [DEPTH];
  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_busy;
  logic              r_rsp_valid;
  logic [WIDTH-1:0]  r_rsp_rdata;

  logic              w_clearing, w_accept, w_rd_acc, w_wr_en, w_in_range;
  logic [ADDR_W-1:0] w_dec_addr;
  logic [DEPTH-1:0]  w_sel;
  logic [MEM_W-1:0]  w_wr_word, w_rd_word;

  assign w_clearing    = (r_state == ST_CLEAR);
  assign bus.req_ready = (r_state == ST_IDLE) && !bus.clr_start;
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_rd_acc      = w_accept && (bus.req_op == OP_READ);
  assign w_wr_en       = w_clearing || (w_accept && (bus.req_op == OP_WRITE));

  // The clear sweep and the request port share one decoder; they never overlap.
  assign w_dec_addr = w_clearing ? r_clr_cnt : bus.req_addr;

  address_decoder #(.DEPTH(DEPTH)) u_dec (
    .i_addr    (w_dec_addr),
    .i_en      (w_clearing || w_accept),
    .o_sel     (w_sel),
    .o_in_range(w_in_range)
  );

`ifdef MEMORY_BANK_PARITY_EN
  assign w_wr_word = w_clearing ? '0 :
    {even_parity(PARITY_MAX_W'(bus.req_wdata)) ^ bus.err_inject, bus.req_wdata};
`else
  assign w_wr_word = w_clearing ? '0 : bus.req_wdata;
`endif

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel[i]) w_rd_word = w_rd_word | r_mem[i];
    end
  end

  // NOTE: the array has no reset; contents stay undefined until written or cleared.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_sel[i]) r_mem[i] <= w_wr_word;
      end
    end
  end

`ifdef MEMORY_BANK_PARITY_EN
  logic r_parity_err;
  assign bus.parity_err = r_parity_err;
`endif

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_clr_cnt   <= '0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef MEMORY_BANK_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= w_rd_acc;
      if (w_rd_acc) r_rsp_rdata <= w_in_range ? w_rd_word[WIDTH-1:0] : '0;
`ifdef MEMORY_BANK_PARITY_EN
      // Stored word XORs to 1 exactly when its parity bit disagrees with the data.
      r_parity_err <= w_rd_acc && w_in_range && (^w_rd_word);
`endif
      case (r_state)
        ST_IDLE: begin
          if (bus.clr_start) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
            r_busy    <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule
